rr_lock_arbiter: RTL and testbench

- Parametrised round-robin arbiter for a shared resource, e.g. a memory port shared by N cores.
- Unlike a per-cycle arbiter, a grant is locked to one requester until the resource signals release, the requester drops its request, or a hold timeout expires.
- A runtime mode input selects rotating round-robin or fixed lowest-index-first priority.
- Sits between core request lines and the shared-bus mux, which it drives with a one-hot select plus an encoded index.

---
 rtl/rr_lock_arbiter.sv | 105 ++++++++++
 tb/tb_rr_lock_arbiter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/rr_lock_arbiter.sv
// Round-robin / fixed-priority arbiter that locks a grant until release, request drop or hold timeout.
// The resource-done input is named release_in because 'release' is a reserved SystemVerilog keyword.
module rr_lock_arbiter #(
  parameter int NUM_ENTRIES = 4,
  parameter int INDEX_WIDTH = 2,
  parameter int MAX_HOLD    = 16,
  parameter int HOLD_WIDTH  = 5
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_ENTRIES-1:0] request,
  input  logic                   release_in,
  input  logic                   fixed_priority,
  output logic [NUM_ENTRIES-1:0] core_select,
  output logic                   grant_valid,
  output logic [INDEX_WIDTH-1:0] grant_index,
  output logic                   hold_timeout
);

  typedef enum logic {IDLE, GRANTED} state_t;

  localparam bit                  HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [HOLD_WIDTH-1:0] HOLD_LAST = HOLD_EN ? HOLD_WIDTH'(MAX_HOLD - 1) : '0;

  state_t                   r_state;
  logic [NUM_ENTRIES-1:0]   r_base;
  logic [HOLD_WIDTH-1:0]    r_hold_count;
  logic [NUM_ENTRIES-1:0]   r_core_select;
  logic                     r_grant_valid;
  logic [INDEX_WIDTH-1:0]   r_grant_index;
  logic                     r_hold_timeout;

  logic [2*NUM_ENTRIES-1:0] w_req_dbl;
  logic [2*NUM_ENTRIES-1:0] w_dbl_grant;
  logic [NUM_ENTRIES-1:0]   w_rr_pick;
  logic [NUM_ENTRIES-1:0]   w_fixed_pick;
  logic [NUM_ENTRIES-1:0]   w_pick;
  logic [INDEX_WIDTH-1:0]   w_pick_index;
  logic                     w_req_held;
  logic                     w_timeout;
  logic                     w_end;

  function automatic logic [INDEX_WIDTH-1:0] encode(input logic [NUM_ENTRIES-1:0] onehot);
    encode = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (onehot[i]) encode = encode | INDEX_WIDTH'(i);
    end
  endfunction

  // Doubling the request vector lets a single subtract scan upward from base and wrap past the MSB.
  assign w_req_dbl    = {request, request};
  assign w_dbl_grant  = w_req_dbl & ~(w_req_dbl - {{NUM_ENTRIES{1'b0}}, r_base});
  assign w_rr_pick    = w_dbl_grant[NUM_ENTRIES-1:0] | w_dbl_grant[2*NUM_ENTRIES-1:NUM_ENTRIES];
  assign w_fixed_pick = request & (~request + NUM_ENTRIES'(1));
  assign w_pick       = fixed_priority ? w_fixed_pick : w_rr_pick;
  assign w_pick_index = encode(w_pick);

  assign w_req_held = |(request & r_core_select);
  assign w_timeout  = HOLD_EN && (r_hold_count == HOLD_LAST);
  assign w_end      = release_in | ~w_req_held | w_timeout;

  // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= IDLE;
      r_base         <= NUM_ENTRIES'(1);
      r_hold_count   <= '0;
      r_core_select  <= '0;
      r_grant_valid  <= 1'b0;
      r_grant_index  <= '0;
      r_hold_timeout <= 1'b0;
    end else begin
      r_hold_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (|request) begin
            r_core_select <= w_pick;
            r_grant_index <= w_pick_index;
            r_grant_valid <= 1'b1;
            r_hold_count  <= '0;
            r_state       <= GRANTED;
            if (!fixed_priority) r_base <= {w_pick[NUM_ENTRIES-2:0], w_pick[NUM_ENTRIES-1]};
          end
        end
        GRANTED: begin
          r_hold_count <= r_hold_count + HOLD_WIDTH'(1);
          if (w_end) begin
            r_core_select  <= '0;
            r_grant_valid  <= 1'b0;
            r_state        <= IDLE;
            // Pulse only when the timeout alone ended the grant.
            r_hold_timeout <= w_timeout & ~release_in & w_req_held;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign core_select  = r_core_select;
  assign grant_valid  = r_grant_valid;
  assign grant_index  = r_grant_index;
  assign hold_timeout = r_hold_timeout;

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Directed bench for rr_lock_arbiter: reset, rotation, fixed priority, timeout, request drop, async reset.
module tb_rr_lock_arbiter;

  logic       clk;
  logic       reset_n;
  logic [3:0] request;
  logic       release_in;
  logic       fixed_priority;

  logic [3:0] core_select,  core_select0;
  logic       grant_valid,  grant_valid0;
  logic [1:0] grant_index,  grant_index0;
  logic       hold_timeout, hold_timeout0;

  int n_tests = 0;
  int n_fail  = 0;

  rr_lock_arbiter #(.NUM_ENTRIES(4), .INDEX_WIDTH(2), .MAX_HOLD(4), .HOLD_WIDTH(5)) dut (
    .clk(clk), .reset_n(reset_n), .request(request), .release_in(release_in),
    .fixed_priority(fixed_priority), .core_select(core_select), .grant_valid(grant_valid),
    .grant_index(grant_index), .hold_timeout(hold_timeout)
  );

  rr_lock_arbiter #(.NUM_ENTRIES(4), .INDEX_WIDTH(2), .MAX_HOLD(0), .HOLD_WIDTH(5)) dut0 (
    .clk(clk), .reset_n(reset_n), .request(request), .release_in(release_in),
    .fixed_priority(fixed_priority), .core_select(core_select0), .grant_valid(grant_valid0),
    .grant_index(grant_index0), .hold_timeout(hold_timeout0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  logic [3:0] seq1 [9];
  logic [3:0] seq2 [6];
  logic [3:0] seq3 [8];

  initial begin
    seq1 = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
    seq2 = '{4'b0000, 4'b0010, 4'b0000, 4'b1000, 4'b0000, 4'b0010};
    seq3 = '{4'b0000, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b0100};

    // Reset with all requesting
    request = 4'b1111; release_in = 1'b1; fixed_priority = 1'b0; reset_n = 1'b0;
    step(); step();
    check("rst_core_select", core_select, 0);
    check("rst_grant_valid", grant_valid, 0);
    check("rst_grant_index", grant_index, 0);
    check("rst_hold_timeout", hold_timeout, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Full rotation with release held
    for (int i = 0; i < 9; i++) begin
      step();
      check($sformatf("rot4_sel[%0d]", i), core_select, seq1[i]);
      check($sformatf("rot4_valid[%0d]", i), grant_valid, |seq1[i]);
    end

    // Two-requester rotation
    request = 4'b1010;
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("rot2_sel[%0d]", i), core_select, seq2[i]);
    end
    check("rot2_index_last", grant_index, 1);

    // Fixed priority, then back to round-robin from the retained base
    fixed_priority = 1'b1; request = 4'b1110;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) request = 4'b1100;
      if (i == 6) begin fixed_priority = 1'b0; request = 4'b1111; end
      step();
      check($sformatf("fix_sel[%0d]", i), core_select, seq3[i]);
    end
    check("fix_rr_index", grant_index, 2);

    // Hold timeout
    request = 4'b0001; release_in = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("to_valid[%0d]", i), grant_valid, 1);
      check($sformatf("to_pulse[%0d]", i), hold_timeout, 0);
    end
    step();
    check("to_cleared", grant_valid, 0);
    check("to_pulse_hi", hold_timeout, 1);
    step();
    check("to_regrant", core_select, 4'b0001);
    check("to_pulse_lo", hold_timeout, 0);
    check("nohold_valid", grant_valid0, 1);
    for (int i = 0; i < 40; i++) step();
    check("nohold_valid_long", grant_valid0, 1);
    check("nohold_sel_long", core_select0, 4'b0001);
    check("nohold_pulse", hold_timeout0, 0);

    // Request drop at hold_count=1
    request = 4'b0100;
    do_reset();
    step();
    check("drop_grant", core_select, 4'b0100);
    check("drop_index", grant_index, 2);
    step();
    request = 4'b0000;
    step();
    check("drop_cleared", grant_valid, 0);
    check("drop_no_pulse", hold_timeout, 0);

    // Release coincident with the timeout cycle
    request = 4'b0001;
    step();
    check("coin_grant", core_select, 4'b0001);
    step(); step(); step();
    check("coin_still_valid", grant_valid, 1);
    release_in = 1'b1;
    step();
    check("coin_cleared", grant_valid, 0);
    check("coin_no_pulse", hold_timeout, 0);

    // Asynchronous reset mid-grant
    release_in = 1'b0; request = 4'b0100;
    step();
    check("async_pre", core_select, 4'b0100);
    #2 reset_n = 1'b0;
    #1;
    check("async_sel", core_select, 0);
    check("async_valid", grant_valid, 0);
    check("async_index", grant_index, 0);
    request = 4'b1111; release_in = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    step();
    check("post_rst_grant0", core_select, 4'b0001);
    step();
    check("post_rst_idle", core_select, 4'b0000);
    step();
    check("post_rst_grant1", core_select, 4'b0010);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
